avalon_hex_display: RTL and testbench
=====================================

// Module: avalon_hex_display
// PURPOSE
//  Avalon-MM slave driving NUM_DIGITS seven-segment displays: hex decode or raw segment mode,
//  per-digit blank and blink masks, programmable blink rate. Next-generation replacement for
//  the flat 28-bit PIO hex output; sits on the system interconnect, seg_out goes to HEX pins.
// PARAMETERS
//  NUM_DIGITS     4           digits driven, legal 1..8
//  SEG_ACTIVE_LOW 1           1: segment lit = 0 (DE-series boards); 0: lit = 1
//  DIV_W          24          width of BLINK_DIV register and blink counter
//  BLINK_DIV_RST  12_500_000  reset value of BLINK_DIV (half-period, clk cycles)
// PORTS
//  clk        in   1             system clock
//  reset_n    in   1             asynchronous, active-low reset
//  address    in   3             word address
//  chipselect in   1             slave select
//  write_n    in   1             active-low write strobe
//  writedata  in   32            write data
//  readdata   out  32            read data, combinational, zero wait states
//  seg_out    out  NUM_DIGITS*7  digit k = seg_out[7k+6:7k], bit0=a .. bit6=g
// BEHAVIOUR
//  Registers (write when chipselect & ~write_n; unused bits read 0):
//   0 DATA   [4*NUM_DIGITS-1:0] one nibble per digit, digit0 = [3:0]      rst 0
//   1 CTRL   b0 EN, b1 RAW, b2 LZS (macro only)                           rst 0x1
//   2 BLANK  [NUM_DIGITS-1:0] 1 = digit forced off                        rst 0
//   3 BLINK  [NUM_DIGITS-1:0] 1 = digit blinks                            rst 0
//   4 BLINK_DIV [DIV_W-1:0] half-period in clk cycles                     rst BLINK_DIV_RST
//   5 RAW_LO  7 bits per digit, digits 0..3 at [7k+6:7k]                  rst 0
//   6 RAW_HI  digits 4..7, same packing (bits for absent digits ignored)   rst 0
//   7 STATUS  RO: b0 blink phase (1 = on); writes ignored
//  Read: readdata = selected register, 0-extended; no side effects.
//  Blink: counter counts 0..BLINK_DIV-1; at terminal count wraps to 0 and toggles phase.
//   Write to BLINK_DIV clears counter and sets phase = on in the same cycle.
//   BLINK_DIV = 0: counter held 0, phase held on (blinking digits shown steady).
//  Per-digit pattern (1 = lit): EN=0 or BLANK[k] or (BLINK[k] & phase off) -> all off;
//   else RAW=1 -> raw bits; else hex decode of nibble 0..F (0-9,A,b,C,d,E,F).
//  seg_out registered: new register value visible exactly 1 cycle after write accept.
//  SEG_ACTIVE_LOW inverts the final pattern only; registers hold logical values.
//  Reset: all registers to reset values, phase on, counter 0, seg_out = all segments off.
//  Reset mid-blink or mid-write: write discarded, state as above, no glitch beyond 1 cycle.
// CONFIGURATION
//  HEX_LZS_EN defined: CTRL.b2 implemented; in decode mode, zero digits above the highest
//   nonzero digit are shown off; digit0 never suppressed (DATA=0 shows "0"). RAW mode unaffected.
//  HEX_LZS_EN undefined: CTRL.b2 not stored, reads 0, no suppression logic.
// STRUCTURE
//  hex_display_pkg: register address localparams, CTRL bit indices, 16-entry 7-bit
//   hex-to-segment table (logical polarity).
//  Sub-module hex7seg_decoder (4-bit in, 7-bit out, combinational), one instance per digit
//   via generate; blink counter, register file and output register stay in top level.
// TESTING
//  Reset, NUM_DIGITS=4, SEG_ACTIVE_LOW=1: seg_out=28'hFFFFFFF; next cycle digits show "0",
//   each digit 7'b1000000.
//  Write DATA=0x0000_12AF -> 1 cycle later digit0 F=7'b0001110, digit1 A=7'b0001000,
//   digit2 2=7'b0100100, digit3 1=7'b1111001; read addr 0 returns 0x0000_12AF.
//  BLINK_DIV=4, BLINK=4'b0001 -> digit0 toggles off/on every 4 cycles, others steady;
//   STATUS.b0 tracks phase; BLINK_DIV=0 -> digit0 steady on.
//  CTRL=0x3, RAW_LO=0x0000_007F -> digit0 all segments lit (7'b0000000), digits 1..3 off;
//   BLANK=4'b0001 -> digit0 off; CTRL=0x0 -> all off.
//  HEX_LZS_EN, CTRL=0x5, DATA=0x0000_0042 -> digits 3,2 off, digit1 "4", digit0 "2";
//   DATA=0 -> only digit0 "0". Without macro, CTRL reads 0x1.
//  Assert reset_n mid-count with BLINK active -> seg_out all off immediately; after release,
//   BLINK_DIV reads BLINK_DIV_RST, STATUS.b0=1.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared definitions for the Avalon-MM seven-segment display controller:
// register map, CTRL bit positions and the hex-to-segment table (1 = lit).
package hex_display_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_CTRL      = 3'd1;
  localparam logic [2:0] ADDR_BLANK     = 3'd2;
  localparam logic [2:0] ADDR_BLINK     = 3'd3;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd4;
  localparam logic [2:0] ADDR_RAW_LO    = 3'd5;
  localparam logic [2:0] ADDR_RAW_HI    = 3'd6;
  localparam logic [2:0] ADDR_STATUS    = 3'd7;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_RAW = 1;
  localparam int CTRL_LZS = 2;

  // Entry n is the pattern for nibble n, bit0 = segment a .. bit6 = segment g.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble to seven-segment decoder, logical polarity (1 = lit).
module hex7seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/avalon_hex_display.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment digits with hex/raw modes,
// blank and blink masks. Define HEX_LZS_EN to add leading-zero suppression (CTRL.b2).
module avalon_hex_display
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIV_W          = 24,
  parameter int unsigned BLINK_DIV_RST  = 12_500_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*7-1:0] seg_out
);

  localparam int unsigned SEG_W     = NUM_DIGITS * 7;
  localparam int unsigned LO_DIGITS = (NUM_DIGITS < 4) ? NUM_DIGITS : 4;
  localparam logic [SEG_W-1:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic [4*NUM_DIGITS-1:0]     data;
  logic                        ctrl_en;
  logic                        ctrl_raw;
  logic                        ctrl_lzs;
  logic [NUM_DIGITS-1:0]       blank;
  logic [NUM_DIGITS-1:0]       blink;
  logic [DIV_W-1:0]            blink_div;
  logic [DIV_W-1:0]            blink_cnt;
  logic                        phase;
  logic [NUM_DIGITS-1:0][6:0]  raw;
  logic [NUM_DIGITS-1:0][6:0]  dec;
  logic [NUM_DIGITS-1:0][6:0]  pattern;
  logic [NUM_DIGITS-1:0]       lzs_off;
  logic [SEG_W-1:0]            seg_next;
  logic                        wr;

  assign wr = chipselect & ~write_n;

  // Register file writes; STATUS is read-only so its address falls to default.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      ctrl_en   <= 1'b1;
      ctrl_raw  <= 1'b0;
      blank     <= '0;
      blink     <= '0;
      blink_div <= DIV_W'(BLINK_DIV_RST);
      raw       <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:      data      <= writedata[4*NUM_DIGITS-1:0];
        ADDR_CTRL: begin
          ctrl_en  <= writedata[CTRL_EN];
          ctrl_raw <= writedata[CTRL_RAW];
        end
        ADDR_BLANK:     blank     <= writedata[NUM_DIGITS-1:0];
        ADDR_BLINK:     blink     <= writedata[NUM_DIGITS-1:0];
        ADDR_BLINK_DIV: blink_div <= writedata[DIV_W-1:0];
        ADDR_RAW_LO: begin
          for (int k = 0; k < LO_DIGITS; k++) raw[k] <= writedata[7*k +: 7];
        end
        ADDR_RAW_HI: begin
          for (int k = 4; k < NUM_DIGITS; k++) raw[k] <= writedata[7*(k-4) +: 7];
        end
        default: ;
      endcase
    end
  end

`ifdef HEX_LZS_EN
  // Leading-zero suppression enable bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_lzs <= 1'b0;
    end else if (wr && (address == ADDR_CTRL)) begin
      ctrl_lzs <= writedata[CTRL_LZS];
    end
  end

  // A digit above digit0 goes dark when it and every digit above it are zero.
  always_comb begin
    logic upper_zero;
    lzs_off    = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (data[4*k +: 4] == 4'd0);
      lzs_off[k] = ctrl_lzs & upper_zero;
    end
  end
`else
  assign ctrl_lzs = 1'b0;
  assign lzs_off  = '0;
`endif

  // Blink timebase; a BLINK_DIV write restarts the period in the "on" phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wr && (address == ADDR_BLINK_DIV)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_div == '0) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == (blink_div - DIV_W'(1))) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + DIV_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex7seg_decoder u_dec (
      .nibble (data[4*g +: 4]),
      .seg    (dec[g])
    );
  end

  // Per-digit pattern selection and output polarity.
  always_comb begin
    pattern  = '0;
    seg_next = SEG_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!ctrl_en || blank[k] || (blink[k] && !phase)) begin
        pattern[k] = 7'd0;
      end else if (ctrl_raw) begin
        pattern[k] = raw[k];
      end else if (lzs_off[k]) begin
        pattern[k] = 7'd0;
      end else begin
        pattern[k] = dec[k];
      end
      if (SEG_ACTIVE_LOW != 0) begin
        seg_next[7*k +: 7] = ~pattern[k];
      end else begin
        seg_next[7*k +: 7] = pattern[k];
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out <= SEG_OFF;
    end else begin
      seg_out <= seg_next;
    end
  end

  // Zero-wait-state read mux, unused bits zero.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:      readdata[4*NUM_DIGITS-1:0] = data;
      ADDR_CTRL:      readdata[2:0] = {ctrl_lzs, ctrl_raw, ctrl_en};
      ADDR_BLANK:     readdata[NUM_DIGITS-1:0] = blank;
      ADDR_BLINK:     readdata[NUM_DIGITS-1:0] = blink;
      ADDR_BLINK_DIV: readdata[DIV_W-1:0] = blink_div;
      ADDR_RAW_LO: begin
        for (int k = 0; k < LO_DIGITS; k++) readdata[7*k +: 7] = raw[k];
      end
      ADDR_RAW_HI: begin
        for (int k = 4; k < NUM_DIGITS; k++) readdata[7*(k-4) +: 7] = raw[k];
      end
      ADDR_STATUS:    readdata[0] = phase;
      default:        readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_avalon_hex_display.sv
// Self-checking bench for avalon_hex_display (4 digits, active-low segments):
// directed vector table, blink/reset sequences, then random traffic against a model.
module tb_avalon_hex_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [27:0] seg_out;

  int checks = 0;
  int errors = 0;

  avalon_hex_display #(
    .NUM_DIGITS     (4),
    .SEG_ACTIVE_LOW (1),
    .DIV_W          (24),
    .BLINK_DIV_RST  (12_500_000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_out    (seg_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m_data;
  logic        m_en, m_raw_mode, m_lzs;
  logic [3:0]  m_blank, m_blink;
  logic [23:0] m_div;
  logic [6:0]  m_raw [4];
  longint      m_t;
  logic [27:0] exp_seg;

  function automatic logic [6:0] hex_lit(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  // Phase is "on" during even-numbered half-periods since the last divider write.
  function automatic logic model_phase();
    if (m_div == 24'd0) return 1'b1;
    return ((m_t / longint'(m_div)) % 2) == 0;
  endfunction

  function automatic logic [27:0] model_seg();
    logic [27:0] r;
    logic [6:0]  lit;
    r = 28'd0;
    for (int k = 0; k < 4; k++) begin
      if (!m_en || m_blank[k] || (m_blink[k] && !model_phase())) lit = 7'd0;
      else if (m_raw_mode) lit = m_raw[k];
      else if (m_lzs && k > 0 && (m_data >> (4 * k)) == 16'd0) lit = 7'd0;
      else lit = hex_lit(m_data[4*k +: 4]);
      r[7*k +: 7] = ~lit;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {16'd0, m_data};
      3'd1: return {29'd0, m_lzs, m_raw_mode, m_en};
      3'd2: return {28'd0, m_blank};
      3'd3: return {28'd0, m_blink};
      3'd4: return {8'd0, m_div};
      3'd5: return {4'd0, m_raw[3], m_raw[2], m_raw[1], m_raw[0]};
      3'd7: return {31'd0, model_phase()};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= 16'd0; m_en <= 1'b1; m_raw_mode <= 1'b0; m_lzs <= 1'b0;
      m_blank <= 4'd0; m_blink <= 4'd0; m_div <= 24'd12_500_000; m_t <= 0;
      for (int k = 0; k < 4; k++) m_raw[k] <= 7'd0;
      exp_seg <= 28'hFFF_FFFF;
    end else begin
      exp_seg <= model_seg();
      m_t <= m_t + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[15:0];
          3'd1: begin
            m_en       <= writedata[0];
            m_raw_mode <= writedata[1];
`ifdef HEX_LZS_EN
            m_lzs      <= writedata[2];
`endif
          end
          3'd2: m_blank <= writedata[3:0];
          3'd3: m_blink <= writedata[3:0];
          3'd4: begin m_div <= writedata[23:0]; m_t <= 0; end
          3'd5: for (int k = 0; k < 4; k++) m_raw[k] <= writedata[7*k +: 7];
          default: ;
        endcase
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  function automatic logic [27:0] segs(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] rexp;
    logic [27:0] sexp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] prev;
    logic [31:0] ctrl7_rd;
    logic        st  [24];
    logic [6:0]  d0  [24];
    logic [20:0] up  [24];
    int          last_tr, ntr;

`ifdef HEX_LZS_EN
    ctrl7_rd = 32'h7;
`else
    ctrl7_rd = 32'h3;
`endif
    // off = 7F, "0" = 40, "1" = 79, "2" = 24, "4" = 19, "A" = 08, "F" = 0E
    vecs[0]  = '{3'd0, 32'h0000_12AF, 3'd0, 32'h0000_12AF, segs(7'h79, 7'h24, 7'h08, 7'h0E)};
    vecs[1]  = '{3'd2, 32'h0000_0002, 3'd2, 32'h0000_0002, segs(7'h79, 7'h24, 7'h7F, 7'h0E)};
    vecs[2]  = '{3'd2, 32'h0000_0000, 3'd7, 32'h0000_0001, segs(7'h79, 7'h24, 7'h08, 7'h0E)};
    vecs[3]  = '{3'd1, 32'h0000_0003, 3'd1, 32'h0000_0003, segs(7'h7F, 7'h7F, 7'h7F, 7'h7F)};
    vecs[4]  = '{3'd5, 32'h0000_007F, 3'd5, 32'h0000_007F, segs(7'h7F, 7'h7F, 7'h7F, 7'h00)};
    vecs[5]  = '{3'd2, 32'h0000_0001, 3'd2, 32'h0000_0001, segs(7'h7F, 7'h7F, 7'h7F, 7'h7F)};
    vecs[6]  = '{3'd2, 32'h0000_0000, 3'd6, 32'h0000_0000, segs(7'h7F, 7'h7F, 7'h7F, 7'h00)};
    vecs[7]  = '{3'd6, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000, segs(7'h7F, 7'h7F, 7'h7F, 7'h00)};
    vecs[8]  = '{3'd1, 32'h0000_0000, 3'd1, 32'h0000_0000, segs(7'h7F, 7'h7F, 7'h7F, 7'h7F)};
    vecs[9]  = '{3'd1, 32'h0000_0007, 3'd1, ctrl7_rd,      segs(7'h7F, 7'h7F, 7'h7F, 7'h00)};
    vecs[10] = '{3'd1, 32'h0000_0001, 3'd1, 32'h0000_0001, segs(7'h79, 7'h24, 7'h08, 7'h0E)};
    vecs[11] = '{3'd7, 32'h0000_0000, 3'd7, 32'h0000_0001, segs(7'h79, 7'h24, 7'h08, 7'h0E)};
    vecs[12] = '{3'd0, 32'hFFFF_FFFF, 3'd0, 32'h0000_FFFF, segs(7'h0E, 7'h0E, 7'h0E, 7'h0E)};
    vecs[13] = '{3'd4, 32'hFF12_3456, 3'd4, 32'h0012_3456, segs(7'h0E, 7'h0E, 7'h0E, 7'h0E)};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd4; writedata = 32'd0;

    // Reset state
    @(negedge clk);
    check("rst_seg", {4'd0, seg_out}, 32'h0FFF_FFFF);
    check("rst_div", readdata, 32'd12_500_000);
    address = 3'd1; #1;
    check("rst_ctrl", readdata, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("first_seg", {4'd0, seg_out}, {4'd0, segs(7'h40, 7'h40, 7'h40, 7'h40)});

    // Directed table: unchanged right after the accepting edge, new value one cycle later
    prev = segs(7'h40, 7'h40, 7'h40, 7'h40);
    for (int i = 0; i < NV; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      address = vecs[i].raddr;
      check($sformatf("vec%0d_hold", i), {4'd0, seg_out}, {4'd0, prev});
      @(negedge clk);
      check($sformatf("vec%0d_seg", i), {4'd0, seg_out}, {4'd0, vecs[i].sexp});
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].rexp);
      prev = vecs[i].sexp;
    end

    // Blink with half-period 4 on digit0
    wr(3'd0, 32'h0000_12AF);
    wr(3'd4, 32'd4);
    wr(3'd3, 32'h1);
    address = 3'd7;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      st[i] = readdata[0];
      d0[i] = seg_out[6:0];
      up[i] = seg_out[27:7];
    end
    last_tr = -1; ntr = 0;
    for (int i = 0; i < 24; i++) begin
      check($sformatf("blink_upper%0d", i), {11'd0, up[i]}, {11'd0, 7'h79, 7'h24, 7'h08});
      if (i > 0) begin
        check($sformatf("blink_d0_%0d", i), {25'd0, d0[i]}, st[i-1] ? 32'h0E : 32'h7F);
        if (st[i] != st[i-1]) begin
          if (last_tr >= 0) check($sformatf("blink_gap%0d", i), i - last_tr, 32'd4);
          last_tr = i;
          ntr++;
        end
      end
    end
    check("blink_transitions", (ntr >= 4) ? 32'd1 : 32'd0, 32'd1);

    // Divider zero: steady on
    wr(3'd4, 32'd0);
    address = 3'd7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("div0_phase%0d", i), readdata, 32'h1);
      check($sformatf("div0_d0_%0d", i), {25'd0, seg_out[6:0]}, 32'h0E);
    end

    // Reset in the middle of a blink period
    wr(3'd4, 32'd4);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("midrst_seg", {4'd0, seg_out}, 32'h0FFF_FFFF);
    @(negedge clk);
    reset_n = 1'b1;
    address = 3'd4; #1;
    check("midrst_div", readdata, 32'd12_500_000);
    address = 3'd7; #1;
    check("midrst_phase", readdata, 32'h1);
    address = 3'd3; #1;
    check("midrst_blink", readdata, 32'h0);
    @(negedge clk);
    check("midrst_seg_after", {4'd0, seg_out}, {4'd0, segs(7'h40, 7'h40, 7'h40, 7'h40)});

`ifdef HEX_LZS_EN
    wr(3'd1, 32'h5);
    wr(3'd0, 32'h0000_0042);
    @(negedge clk);
    check("lzs_42", {4'd0, seg_out}, {4'd0, segs(7'h7F, 7'h7F, 7'h19, 7'h24)});
    wr(3'd0, 32'h0);
    @(negedge clk);
    check("lzs_0", {4'd0, seg_out}, {4'd0, segs(7'h7F, 7'h7F, 7'h7F, 7'h40)});
    wr(3'd1, 32'h1);
`else
    wr(3'd1, 32'h5);
    address = 3'd1;
    @(negedge clk);
    check("ctrl_no_lzs", readdata, 32'h1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check("rnd_seg", {4'd0, seg_out}, {4'd0, exp_seg});
      check("rnd_rd", readdata, model_read(address));
      chipselect = ($urandom_range(0, 2) == 0);
      write_n    = $urandom_range(0, 1);
      address    = 3'($urandom_range(0, 7));
      writedata  = (address == 3'd4) ? 32'($urandom_range(0, 6)) : $urandom;
    end
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    check("rnd_seg_last", {4'd0, seg_out}, {4'd0, exp_seg});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
